div_iter: RTL and testbench

Parametrised iterative integer divider for the execute stage. It replaces the vendor divider cores and their per-core tvalid/tready and cycle-counter glue with one restoring radix-2 unit. It handles signed and unsigned operands, returns both quotient and remainder, uses valid/ready handshakes on both sides, and supports a pipeline flush that cancels an in-flight operation. The execute stage issues one division, stalls `ready_go` until `out_valid`, and drops the operation on exception or ertn flush.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 28 ++
 rtl/div_iter.sv | 131 +++++++++++++
 tb/tb_div_iter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, divide-by-zero
// quotient fill and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Every quotient bit is set on a divide by zero, whatever the width.
    localparam logic DIV0_QUO_BIT = 1'b1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quo} left by one and
// trial-subtract the divisor, keeping the difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {2'b00, div};
        rem_next = shifted[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            rem_next = diff[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned restoring divider with valid/ready handshakes on
// both sides and a flush that cancels the operation in flight.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic [WIDTH-1:0] out_rem
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] a_raw;
    logic             sign_q;
    logic             sign_r;
    logic             div0;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    assign neg_a = in_signed & in_a[WIDTH-1];
    assign neg_b = in_signed & in_b[WIDTH-1];
    assign abs_a = neg_a ? -in_a : in_a;
    assign abs_b = neg_b ? -in_b : in_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .div      (div_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            a_raw     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div0      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem_q    <= '0;
                        quo_q    <= abs_a;
                        div_q    <= abs_b;
                        a_raw    <= in_a;
                        sign_q   <= neg_a ^ neg_b;
                        sign_r   <= neg_a;
                        div0     <= (in_b == '0);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Sign fix-up and divide-by-zero override act on the stored magnitudes;
    // MIN / -1 falls out naturally as MIN with a zero remainder.
    always_comb begin
        out_quo = '0;
        out_rem = '0;
        if (out_valid) begin
            if (div0) begin
                out_quo = {WIDTH{DIV0_QUO_BIT}};
                out_rem = a_raw;
            end else begin
                out_quo = sign_q ? -quo_q : quo_q;
                out_rem = WIDTH'(sign_r ? -rem_q : rem_q);
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed WIDTH=32 cases with timing checks and
// randomized WIDTH=8 operations against an arithmetic reference model.
module tb_div_iter;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic        in_valid, in_signed, flush, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid;
    logic [31:0] out_quo, out_rem;

    logic        in_valid8, in_signed8, flush8, out_ready8;
    logic [7:0]  in_a8, in_b8;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_quo8, out_rem8;

    div_iter #(.WIDTH(32)) u_div32 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quo   (out_quo),
        .out_rem   (out_rem)
    );

    div_iter #(.WIDTH(8)) u_div8 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_signed (in_signed8),
        .in_a      (in_a8),
        .in_b      (in_b8),
        .flush     (flush8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_quo   (out_quo8),
        .out_rem   (out_rem8)
    );

    res_t q32[$];
    res_t q8[$];
    res_t e32, e8;
    int   checks = 0;
    int   errors = 0;
    int   pops32 = 0;
    logic rand_phase = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Truncating signed/unsigned division done in 64-bit arithmetic.
    function automatic res_t model(input int w, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if ((b & mask) == 32'd0) begin
            r.quo = mask;
            r.rem = a & mask;
            return r;
        end
        sa = longint'(a & mask);
        sb = longint'(b & mask);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        r.quo = 32'(sa / sb) & mask;
        r.rem = 32'(sa % sb) & mask;
        return r;
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (resetn && out_valid && out_ready) begin
            pops32++;
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out32: got quo %0h rem %0h, no result expected", out_quo, out_rem);
            end else begin
                e32 = q32.pop_front();
                check("quo32", out_quo, e32.quo);
                check("rem32", out_rem, e32.rem);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (resetn && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got quo %0h rem %0h, no result expected", out_quo8, out_rem8);
            end else begin
                e8 = q8.pop_front();
                check("quo8", out_quo8, e8.quo[7:0]);
                check("rem8", out_rem8, e8.rem[7:0]);
            end
        end
    end

    always @(negedge clk) out_ready8 = rand_phase ? ($urandom_range(0, 3) != 0) : 1'b1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready32();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
    endtask

    // Accept at the next edge, then count cycles until out_valid (out_ready high).
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input string tag);
        int lat;
        @(negedge clk);
        wait_ready32();
        in_valid  = 1'b1;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        @(posedge clk);
        q32.push_back('{eq, er});
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        @(negedge clk);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    task automatic start_no_push(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        wait_ready32();
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = a;
        in_b      = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic watch_quiet(input string tag);
        int seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int          n;
        int          p;
        logic        sgn;
        logic [7:0]  a8, b8;
        res_t        r;

        resetn = 1'b0;
        in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; flush = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_signed8 = 1'b0; in_a8 = '0; in_b8 = '0; flush8 = 1'b0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_quo", out_quo, 0);
        check("reset_out_rem", out_rem, 0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "u_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "s_7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "s_overflow");
        run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "s_div0");
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "u_div0");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "s_div0_neg");

        // Flush in CALC cycle 10.
        start_no_push(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_in_ready", in_ready, 1);
        check("flush_calc_out_valid", out_valid, 0);
        watch_quiet("flush_calc_quiet");
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "after_flush");

        // Flush coincident with the input handshake.
        @(negedge clk);
        in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd100; in_b = 32'd7; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_in_ready", in_ready, 1);
        watch_quiet("flush_accept_quiet");

        // Reset pulse mid-CALC.
        start_no_push(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_quo", out_quo, 0);
        @(negedge clk);
        resetn = 1'b1;
        watch_quiet("rst_mid_quiet");
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "after_reset");

        // Back-pressure in DONE.
        out_ready = 1'b0;
        @(negedge clk);
        wait_ready32();
        in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd1000; in_b = 32'd3;
        @(posedge clk);
        q32.push_back('{32'd333, 32'd1});
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_quo", out_quo, 32'd333);
            check("bp_hold_rem", out_rem, 32'd1);
            check("bp_hold_in_ready", in_ready, 0);
        end
        p = pops32;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        check("bp_single_handshake", 64'(pops32 - p), 64'd1);

        // Randomized WIDTH = 8 operations with random output back-pressure.
        rand_phase = 1'b1;
        for (int k = 0; k < 60; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       b8 = 8'h00;
                1: begin a8 = 8'h80; b8 = 8'hFF; end
                default: b8 = 8'($urandom);
            endcase
            @(negedge clk);
            n = 0;
            while (!in_ready8 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready8) check("in_ready8_timeout", in_ready8, 1);
            in_valid8 = 1'b1; in_signed8 = sgn; in_a8 = a8; in_b8 = b8;
            @(posedge clk);
            r = model(8, sgn, {24'd0, a8}, {24'd0, b8});
            q8.push_back(r);
            @(negedge clk);
            in_valid8 = 1'b0;
            in_a8 = 8'($urandom);
            in_b8 = 8'($urandom);
        end
        rand_phase = 1'b0;

        n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_q32", 64'(q32.size()), 64'd0);
        check("drain_q8", 64'(q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
